// File: rtl/vocab_writer.sv
// -----------------------------------------------------------------------------
// vocab_writer
//
// Packs a stream of character beats into a write-only SRAM port as a list of
// null-terminated words, followed by one extra 0x00 that marks the end of the
// vocabulary. Layout (from address 0):  w0 c.. 00  w1 c.. 00 ... 00
//
// Capacity handling: character beats are only accepted while at least two
// slots remain above the write pointer, so there is always room for the word
// terminator and, at the very top address, for the end-of-vocabulary null.
// A word that runs into that limit is truncated with a forced terminator.
//
// Ports
//   clk, rst_n            clock (posedge) and asynchronous active-low reset
//   in_valid/in_ready     character beat handshake
//   in_data, in_last      character code, last character of a word
//   seal                  request the end-of-vocabulary null
//   mem_cs, mem_we        registered SRAM write strobes (one-cycle pulse)
//   mem_addr, mem_din     registered SRAM write address / data
//   full                  no room for further characters
//   sealed                vocabulary closed; no further writes until reset
//   err                   sticky: zero character seen or word truncated
//   word_count            (only with VOCAB_WRITER_WORD_COUNT_EN) number of
//                         terminators written, forced ones included
//
// Configuration macro: VOCAB_WRITER_WORD_COUNT_EN adds the word_count port.
// -----------------------------------------------------------------------------
module vocab_writer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  seal,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  full,
    output logic                  sealed,
    output logic                  err
`ifdef VOCAB_WRITER_WORD_COUNT_EN
    ,
    output logic [ADDR_WIDTH-1:0] word_count
`endif
);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        TERM   = 2'd1,
        SEAL   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Highest address a character may be written to: leaves one slot for the
    // terminator and the top address for the end-of-vocabulary null.
    localparam logic [ADDR_WIDTH-1:0] LAST_CHAR = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] NUL       = {DATA_WIDTH{1'b0}};

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   wr_ptr_r;
    logic                    seal_pend_r;
    logic                    partial_r;     // characters written since last terminator
    logic                    mem_wr_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_din_r;
    logic                    err_r;
`ifdef VOCAB_WRITER_WORD_COUNT_EN
    logic [ADDR_WIDTH-1:0]   word_count_r;
`endif

    logic                    in_ready_s;
    logic                    full_s;
    logic                    accept_s;

    // Handshake and status decode; depends on registered state only.
    always_comb begin
        in_ready_s = (state_r == ACCEPT) && (wr_ptr_r <= LAST_CHAR);
        full_s     = (state_r == ACCEPT) && (wr_ptr_r >  LAST_CHAR);
        accept_s   = in_valid && in_ready_s;
    end

    // Main FSM: state, write pointer, seal request and registered SRAM port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ACCEPT;
            wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
            seal_pend_r  <= 1'b0;
            partial_r    <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_din_r    <= {DATA_WIDTH{1'b0}};
            err_r        <= 1'b0;
`ifdef VOCAB_WRITER_WORD_COUNT_EN
            word_count_r <= {ADDR_WIDTH{1'b0}};
`endif
        end else begin
            // Strobe is a single-cycle pulse unless a state below issues a write.
            mem_wr_r <= 1'b0;
            if (seal && (state_r != DONE)) begin
                seal_pend_r <= 1'b1;
            end

            case (state_r)
                ACCEPT: begin
                    if (accept_s) begin
                        // An accepted beat wins over any seal request this cycle.
                        if (in_data == NUL) begin
                            // Zero is the terminator code; drop it and flag it.
                            err_r <= 1'b1;
                        end else begin
                            mem_wr_r   <= 1'b1;
                            mem_addr_r <= wr_ptr_r;
                            mem_din_r  <= in_data;
                            wr_ptr_r   <= wr_ptr_r + PTR_ONE;
                            partial_r  <= 1'b1;
                            if (in_last) begin
                                state_r <= TERM;
                            end else if (wr_ptr_r == LAST_CHAR) begin
                                // Out of room mid-word: truncate it.
                                state_r <= TERM;
                                err_r   <= 1'b1;
                            end else begin
                                state_r <= ACCEPT;
                            end
                        end
                    end else if (seal_pend_r) begin
                        // A partial word needs its terminator before the final null.
                        state_r <= partial_r ? TERM : SEAL;
                    end else begin
                        state_r <= ACCEPT;
                    end
                end

                TERM: begin
                    mem_wr_r   <= 1'b1;
                    mem_addr_r <= wr_ptr_r;
                    mem_din_r  <= NUL;
                    wr_ptr_r   <= wr_ptr_r + PTR_ONE;
                    partial_r  <= 1'b0;
`ifdef VOCAB_WRITER_WORD_COUNT_EN
                    word_count_r <= word_count_r + PTR_ONE;
`endif
                    // Go straight to SEAL so the final null follows back-to-back.
                    if (seal_pend_r || seal) begin
                        state_r <= SEAL;
                    end else begin
                        state_r <= ACCEPT;
                    end
                end

                SEAL: begin
                    // Pointer is not advanced: this may be the top address.
                    mem_wr_r    <= 1'b1;
                    mem_addr_r  <= wr_ptr_r;
                    mem_din_r   <= NUL;
                    seal_pend_r <= 1'b0;
                    state_r     <= DONE;
                end

                DONE: begin
                    state_r <= DONE;
                end

                default: begin
                    state_r <= ACCEPT;
                end
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign full     = full_s;
    assign sealed   = (state_r == DONE);
    assign err      = err_r;
    assign mem_cs   = mem_wr_r;
    assign mem_we   = mem_wr_r;
    assign mem_addr = mem_addr_r;
    assign mem_din  = mem_din_r;
`ifdef VOCAB_WRITER_WORD_COUNT_EN
    assign word_count = word_count_r;
`endif

endmodule

// File: tb/tb_vocab_writer.sv
// -----------------------------------------------------------------------------
// tb_vocab_writer
//
// Directed scoreboard bench for vocab_writer (ADDR_WIDTH=4, DATA_WIDTH=8).
// Stimulus pushes the hand-computed SRAM writes {addr,data} into exp_q; a
// monitor on the falling clock edge pops and compares each write the DUT
// issues. Status flags are compared directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_vocab_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       seal = 1'b0;
    logic       mem_cs;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic       full;
    logic       sealed;
    logic       err;
`ifdef VOCAB_WRITER_WORD_COUNT_EN
    logic [3:0] word_count;
`endif

    vocab_writer #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .seal(seal),
        .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .full(full), .sealed(sealed), .err(err)
`ifdef VOCAB_WRITER_WORD_COUNT_EN
        , .word_count(word_count)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [11:0] exp_q[$];
    int          wcyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every SRAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && (mem_cs || mem_we)) begin
            wcyc.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected none",
                         mem_addr, mem_din);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({mem_cs, mem_we, mem_addr, mem_din} !== {2'b11, e}) begin
                    bad++;
                    $display("FAIL write: got cs=%0b we=%0b addr=%0h data=%0h expected addr=%0h data=%0h",
                             mem_cs, mem_we, mem_addr, mem_din, e[11:8], e[7:0]);
                end
            end
        end
    end

    // Offer one beat; wait (bounded) for acceptance; report bubble cycles.
    task automatic send(input logic [7:0] d, input logic l, output int waited);
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) begin
            chk("send_timeout", 32'(waited), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    endtask

    task automatic pulse_seal();
        seal = 1'b1;
        @(posedge clk); #1;
        seal = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wcyc.delete();
    endtask

    initial begin
        int w;
        // ---------------- reset state ----------------
        do_reset();
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_flags", {29'd0, full, sealed, err}, 32'd0);
        chk("rst_mem", {18'd0, mem_cs, mem_we, mem_addr, mem_din}, 32'd0);

        // ---------------- "cat" then seal ----------------
        push(4'd0, 8'h63); push(4'd1, 8'h61); push(4'd2, 8'h74);
        push(4'd3, 8'h00); push(4'd4, 8'h00);
        send(8'h63, 1'b0, w);
        send(8'h61, 1'b0, w);
        send(8'h74, 1'b1, w);
        pulse_seal();
        drain("cat_writes");
        chk("cat_sealed", 32'(sealed), 32'd1);
        chk("cat_err", 32'(err), 32'd0);
        chk("cat_in_ready", 32'(in_ready), 32'd0);
`ifdef VOCAB_WRITER_WORD_COUNT_EN
        chk("cat_word_count", 32'(word_count), 32'd1);
`endif

        // ---------------- capacity truncation ----------------
        do_reset();
        for (int i = 0; i < 14; i++) begin
            push(4'(i), 8'h41 + 8'(i));
        end
        push(4'd14, 8'h00);
        for (int i = 0; i < 14; i++) begin
            send(8'h41 + 8'(i), 1'b0, w);
        end
        // Remaining six beats are offered but must never be taken.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h55;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                chk("cap_in_ready", 32'(in_ready), 32'd0);
                chk("cap_full", 32'(full), 32'd1);
                chk("cap_err", 32'(err), 32'd1);
            end
        end
        in_valid = 1'b0; in_data = 8'h00;
        drain("cap_writes");
        push(4'd15, 8'h00);
        @(negedge clk);
        pulse_seal();
        drain("cap_seal_write");
        chk("cap_sealed", 32'(sealed), 32'd1);
`ifdef VOCAB_WRITER_WORD_COUNT_EN
        chk("cap_word_count", 32'(word_count), 32'd1);
`endif

        // ---------------- zero beat with last ----------------
        do_reset();
        send(8'h00, 1'b1, w);
        chk("zero_handshake", 32'(w), 32'd0);
        @(negedge clk);
        chk("zero_err", 32'(err), 32'd1);
        chk("zero_no_term", 32'(in_ready), 32'd1);
        push(4'd0, 8'h42); push(4'd1, 8'h00);
        send(8'h42, 1'b1, w);
        drain("zero_writes");

        // ---------------- seal with accepted beat ----------------
        do_reset();
        push(4'd0, 8'h41); push(4'd1, 8'h00); push(4'd2, 8'h00);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h41; in_last = 1'b1; seal = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; seal = 1'b0;
        drain("both_writes");
        chk("both_nwrites", 32'(wcyc.size()), 32'd3);
        if (wcyc.size() == 3) begin
            chk("both_consec1", 32'(wcyc[1] - wcyc[0]), 32'd1);
            chk("both_consec2", 32'(wcyc[2] - wcyc[1]), 32'd1);
        end
        chk("both_sealed", 32'(sealed), 32'd1);

        // ---------------- valid held through TERM ----------------
        do_reset();
        push(4'd0, 8'h61); push(4'd1, 8'h00); push(4'd2, 8'h62); push(4'd3, 8'h00);
        send(8'h61, 1'b1, w);
        send(8'h62, 1'b1, w);
        chk("term_bubble", 32'(w), 32'd1);
        drain("term_writes");

        // ---------------- reset mid-word ----------------
        do_reset();
        push(4'd0, 8'h61);
        send(8'h61, 1'b0, w);
        send(8'h62, 1'b0, w);
        chk("midrst_write_live", 32'(mem_cs), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_mem", {18'd0, mem_cs, mem_we, mem_addr, mem_din}, 32'd0);
        chk("midrst_flags", {29'd0, full, sealed, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_partial_drop", 32'(exp_q.size()), 32'd0);
        push(4'd0, 8'h62); push(4'd1, 8'h00);
        send(8'h62, 1'b1, w);
        drain("midrst_writes");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vocab_writer.md
VOCAB_WRITER -- requirements
Module: vocab_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning the SRAM address width; depth is 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning character width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  character beat offered.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  character code.
REQ-008 SHALL have port in_last  input  1  beat is the final character of a word.
REQ-009 SHALL have port seal  input  1  request the end-of-vocabulary null.
REQ-010 SHALL have ports mem_cs, mem_we  output  1 each  SRAM write strobes.
REQ-011 SHALL have ports mem_addr  output  ADDR_WIDTH and mem_din  output  DATA_WIDTH, the SRAM write address and data.
REQ-012 SHALL have ports full, sealed, err  output  1 each  status flags.

Function
REQ-013 SHALL pack null-terminated words into SRAM from address 0, with an extra 0x00 after the last word, in the layout the matcher reads.
REQ-014 SHALL implement FSM states ACCEPT, TERM, SEAL, DONE.
REQ-015 SHALL keep an internal write pointer wr_ptr, ADDR_WIDTH bits, that advances by 1 per SRAM write and never wraps.
REQ-016 SHALL drive in_ready = (state==ACCEPT) && (wr_ptr <= 2^ADDR_WIDTH-3).
- Reserves one slot for the word terminator and the top address for the seal null.
REQ-017 SHALL register mem_cs, mem_we, mem_addr and mem_din.
- A write appears exactly one cycle after the accepting edge, for one cycle.
- mem_cs=mem_we=0 in all other cycles.
REQ-018 SHALL write each accepted nonzero beat at wr_ptr; throughput is one character per cycle in ACCEPT.
REQ-019 SHALL, on an accepted beat with in_last=1, go ACCEPT->TERM.
- TERM writes 0x00 at wr_ptr in the next cycle, then returns to ACCEPT.
- This gives a one-cycle bubble per word.
REQ-020 SHALL consume an accepted beat with in_data==0 without writing it.
- err is set and in_last on that beat is ignored.
REQ-021 SHALL handle a word that reaches capacity without in_last.
- Condition: a nonzero beat is accepted at wr_ptr==2^ADDR_WIDTH-3 with in_last=0.
- Action: enter TERM automatically (truncating the word) and set err.
REQ-022 SHALL assert full while in ACCEPT with wr_ptr > 2^ADDR_WIDTH-3.
REQ-023 SHALL register seal into a pending flag whenever it is high and state is not DONE.
REQ-024 SHALL act on pending seal only in ACCEPT in a cycle with no accepted beat.
- If the current word is partial (chars written since the last terminator): ACCEPT->TERM->SEAL.
- Otherwise: ACCEPT->SEAL.
REQ-025 SHALL give an accepted beat priority over seal when both occur in the same cycle.
REQ-026 SHALL have SEAL write 0x00 at wr_ptr and then enter DONE.
REQ-027 SHALL, in DONE, hold sealed=1 and in_ready=0 and issue no writes until reset.
REQ-028 SHALL keep err sticky until reset.

Reset
REQ-029 SHALL, on rst_n low, immediately force state=ACCEPT, wr_ptr=0, pending seal=0, and the following outputs to 0: mem_cs, mem_we, mem_addr, mem_din, full, sealed, err, word_count.
REQ-030 SHALL drive in_ready=1 from the first cycle after reset release.
REQ-031 SHALL, on reset mid-word or mid-TERM, abandon the write; the next accepted beat writes at address 0.

Configuration
REQ-032 SHALL compile in, with macro VOCAB_WRITER_WORD_COUNT_EN defined, output port word_count  output  ADDR_WIDTH.
- Reset value 0.
- +1 on every TERM write, including forced terminators.
- Not incremented by the SEAL write.
REQ-033 SHALL, without VOCAB_WRITER_WORD_COUNT_EN, omit the port and its counter; all other behaviour is unchanged.

Verification
REQ-034 SHALL cover: beats 0x63, 0x61, 0x74(last), then seal, ADDR_WIDTH=4 -> writes addr0..4 = 63,61,74,00,00; sealed=1; word_count=1; err=0.
REQ-035 SHALL cover: 20 nonzero beats with no in_last -> chars at addr0..13, forced 00 at addr14, err=1, full=1, in_ready=0; then seal -> 00 at addr15.
REQ-036 SHALL cover: beat in_data=0x00, in_last=1 -> handshake completes, no write, wr_ptr unchanged, err=1, no TERM.
REQ-037 SHALL cover: seal high in the same cycle as accepted 0x41(last) -> writes 41 @0, 00 @1, 00 @2 on consecutive cycles, then sealed=1.
REQ-038 SHALL cover: in_valid held high through TERM -> in_ready=0 in TERM, exactly one bubble, next beat written at terminator addr+1.
REQ-039 SHALL cover: rst_n pulsed low after two chars -> all outputs 0 asynchronously; next beat 0x62 written at addr0.
